// File: rtl/seed_loader.sv
// seed_loader: collects eight 8-bit rows from a writer into a 64-bit seed
// grid and hands it to a game controller through a start/run request.
//
// Optional feature macro: GEN_COUNT_EN
//   When defined, adds the gen_count output, a saturating count of cycles
//   spent in RUN. Without it the port and counter do not exist.
//
// Row handshake: a row transfers on a rising clk edge when row_valid and
// row_ready are both 1. row_ready is 1 exactly while the FSM is in LOAD.
// The writer may hold row_valid high or drop it at any time. row_valid is
// ignored whenever row_ready is 0.
//
// Command priority in a single cycle: load_cmd > halt_cmd > run_cmd.
// All outputs are registered. dbg_state mirrors the FSM state:
// 0=IDLE, 1=LOAD, 2=ARMED, 3=RUN.
module seed_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  row_data,
    input  logic        row_valid,
    output logic        row_ready,
    input  logic        load_cmd,
    input  logic        run_cmd,
    input  logic        halt_cmd,
    output logic [63:0] seed,
    output logic        start,
    output logic        loaded,
    output logic [1:0]  dbg_state
`ifdef GEN_COUNT_EN
    ,
    output logic [15:0] gen_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [63:0] seed_next;
    logic        row_ready_next;
    logic        loaded_next;
    logic        start_next;
    logic        accept;

    // A row is taken only while row_ready is high (i.e. in LOAD).
    assign accept    = row_valid && row_ready;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. load_cmd wins from every state, including LOAD,
    // where it restarts the load and drops any row offered that cycle.
    always_comb begin
        state_next = state;
        if (load_cmd) begin
            state_next = LOAD;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                LOAD: begin
                    if (accept && (idx == 3'd7)) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    // halt outranks run, so halt+run stays armed.
                    if (!halt_cmd && run_cmd) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (halt_cmd) begin
                        state_next = ARMED;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Next values for the registered outputs and the row index.
    // seed only changes on LOAD entry or on an accepted row, so it is
    // frozen while start is high.
    always_comb begin
        seed_next      = seed;
        idx_next       = idx;
        loaded_next    = loaded;
        if (load_cmd) begin
            seed_next   = 64'd0;
            idx_next    = 3'd0;
            loaded_next = 1'b0;
        end else if (accept) begin
            seed_next[{idx, 3'b000} +: 8] = row_data;
            if (idx == 3'd7) begin
                // Last row: hold the index instead of wrapping.
                loaded_next = 1'b1;
            end else begin
                idx_next = idx + 3'd1;
            end
        end
        row_ready_next = (state_next == LOAD);
        start_next     = (state_next == RUN);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed      <= 64'd0;
            idx       <= 3'd0;
            loaded    <= 1'b0;
            row_ready <= 1'b0;
            start     <= 1'b0;
        end else begin
            seed      <= seed_next;
            idx       <= idx_next;
            loaded    <= loaded_next;
            row_ready <= row_ready_next;
            start     <= start_next;
        end
    end

`ifdef GEN_COUNT_EN
    logic [15:0] gen_count_next;

    // Run-cycle counter: clears on LOAD entry, counts each RUN cycle,
    // saturates at all-ones, holds otherwise.
    always_comb begin
        gen_count_next = gen_count;
        if (load_cmd) begin
            gen_count_next = 16'd0;
        end else if ((state == RUN) && (gen_count != 16'hFFFF)) begin
            gen_count_next = gen_count + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gen_count <= 16'd0;
        end else begin
            gen_count <= gen_count_next;
        end
    end
`endif

endmodule

// File: tb/tb_seed_loader.sv
// tb_seed_loader: self-checking bench for seed_loader. Table-driven vectors,
// hand-written corner sequences and randomized traffic compared against a
// row-queue model of the loader. Build with +define+GEN_COUNT_EN to cover
// the run-cycle counter.
module tb_seed_loader;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  row_data;
    logic        row_valid;
    logic        row_ready;
    logic        load_cmd;
    logic        run_cmd;
    logic        halt_cmd;
    logic [63:0] seed;
    logic        start;
    logic        loaded;
    logic [1:0]  dbg_state;
`ifdef GEN_COUNT_EN
    logic [15:0] gen_count;
`endif

    always #5 clk = ~clk;

    seed_loader dut (
        .clk       (clk),
        .reset     (reset),
        .row_data  (row_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .load_cmd  (load_cmd),
        .run_cmd   (run_cmd),
        .halt_cmd  (halt_cmd),
        .seed      (seed),
        .start     (start),
        .loaded    (loaded),
        .dbg_state (dbg_state)
`ifdef GEN_COUNT_EN
        ,
        .gen_count (gen_count)
`endif
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The loader is modelled as a mode plus the list of rows accepted since
    // the last load command; seed and loaded are derived from that list.
    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_ARMED = 2;
    localparam int M_RUN   = 3;

    int         m_mode;
    logic [7:0] m_rows[$];
    int         m_gc;

    function automatic logic [63:0] m_seed();
        logic [63:0] s;
        s = 64'd0;
        for (int i = 0; i < m_rows.size(); i++) s[8*i +: 8] = m_rows[i];
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_rows.delete();
        m_gc = 0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic h,
                              input logic v, input logic [7:0] d);
        if (l) begin
            m_mode = M_LOAD;
            m_rows.delete();
            m_gc = 0;
        end else if (m_mode == M_LOAD) begin
            if (v) begin
                m_rows.push_back(d);
                if (m_rows.size() == 8) m_mode = M_ARMED;
            end
        end else if (m_mode == M_ARMED) begin
            if (!h && r) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (m_gc < 65535) m_gc++;
            if (h) m_mode = M_ARMED;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_seed"},   seed,      m_seed());
        chk({tag, "_ready"},  row_ready, (m_mode == M_LOAD));
        chk({tag, "_loaded"}, loaded,    (m_rows.size() == 8));
        chk({tag, "_start"},  start,     (m_mode == M_RUN));
`ifdef GEN_COUNT_EN
        chk({tag, "_gc"},     gen_count, m_gc);
`endif
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the next rising edge.
    task automatic step(input logic l, input logic r, input logic h,
                        input logic v, input logic [7:0] d);
        load_cmd  = l;
        run_cmd   = r;
        halt_cmd  = h;
        row_valid = v;
        row_data  = d;
        @(posedge clk);
        model_step(l, r, h, v, d);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic full_load(input logic [7:0] base);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, base + 8'(i));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        l;
        logic        r;
        logic        h;
        logic        v;
        logic [7:0]  d;
        logic [63:0] e_seed;
        logic        e_rdy;
        logic        e_ld;
        logic        e_st;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(logic l, logic r, logic h, logic v, logic [7:0] d,
                                logic [63:0] es, logic er, logic el, logic est);
        vec_t t;
        t.l = l; t.r = r; t.h = h; t.v = v; t.d = d;
        t.e_seed = es; t.e_rdy = er; t.e_ld = el; t.e_st = est;
        return t;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int k;
        logic v;
        logic [63:0] held;

        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 64'h0,                er1(), 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, 8'h01, 64'h01,               1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 8'h02, 64'h0201,             1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 1, 8'h03, 64'h030201,           1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 1, 8'h04, 64'h04030201,         1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 1, 8'h05, 64'h0504030201,       1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 1, 8'h06, 64'h060504030201,     1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 1, 8'h07, 64'h07060504030201,   1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 1, 8'h08, 64'h0807060504030201, 0, 1, 0);
        tbl[9]  = mk(0, 1, 0, 0, 8'h00, 64'h0807060504030201, 0, 1, 1);
        tbl[10] = mk(0, 0, 1, 0, 8'h00, 64'h0807060504030201, 0, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 8'h00, 64'h0807060504030201, 0, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 8'h00, 64'h0807060504030201, 0, 1, 1);
        tbl[13] = mk(1, 1, 1, 0, 8'h00, 64'h0,                1, 0, 0);

        // Reset state
        reset = 1'b0;
        load_cmd = 0; run_cmd = 0; halt_cmd = 0; row_valid = 0; row_data = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_model("reset");
        reset = 1'b1;

        // Table: full load, run/halt, priority
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].l, tbl[i].r, tbl[i].h, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_seed", i),   seed,      tbl[i].e_seed);
            chk($sformatf("tbl%0d_ready", i),  row_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_loaded", i), loaded,    tbl[i].e_ld);
            chk($sformatf("tbl%0d_start", i),  start,     tbl[i].e_st);
        end

        // Backpressure: row_valid toggling every other cycle
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        k = 0;
        for (int c = 0; c < 16; c++) begin
            v = (c % 2 == 0);
            step(1'b0, 1'b0, 1'b0, v, v ? 8'(k + 1) : 8'hEE);
            if (v) k++;
            check_model("gap");
        end
        chk("gap_seed",   seed,      64'h0807060504030201);
        chk("gap_loaded", loaded,    1'b1);
        chk("gap_ready",  row_ready, 1'b0);
        // Rows offered while armed are ignored
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        chk("armed_ignore_seed", seed, 64'h0807060504030201);

        // Run for 10 cycles then halt
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("run_start", start, 1'b1);
        for (int c = 0; c < 9; c++) idle();
        chk("run_still", start, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("halt_start", start, 1'b0);
        chk("halt_seed",  seed,  64'h0807060504030201);
`ifdef GEN_COUNT_EN
        chk("halt_gc", gen_count, 16'd10);
`endif
        for (int c = 0; c < 3; c++) idle();
        check_model("armed_hold");
`ifdef GEN_COUNT_EN
        chk("armed_gc_hold", gen_count, 16'd10);
`endif

        // Restart collision: load_cmd with the 4th row
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h33);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h44);
        chk("coll_seed",   seed,      64'h0);
        chk("coll_loaded", loaded,    1'b0);
        chk("coll_ready",  row_ready, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA1);
        chk("coll_idx0", seed, 64'hA1);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA1 + 8'(i));
        chk("coll_final", seed, 64'hA8A7A6A5A4A3A2A1);
        chk("coll_loaded_final", loaded, 1'b1);

        // Async reset mid-load, between clock edges
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A + 8'(i));
        load_cmd = 0; run_cmd = 0; halt_cmd = 0; row_valid = 0; row_data = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_seed",   seed,      64'h0);
        chk("arst_ready",  row_ready, 1'b0);
        chk("arst_loaded", loaded,    1'b0);
        chk("arst_start",  start,     1'b0);
`ifdef GEN_COUNT_EN
        chk("arst_gc", gen_count, 16'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("arst_run_ignored", start, 1'b0);
        check_model("arst_after");
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'h77);
        chk("idle_row_ignored", seed, 64'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                 8'($urandom_range(0, 255)));
            check_model("rand");
        end

        // Seed stays frozen across a long run
        full_load(8'hC0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        held = seed;
`ifdef GEN_COUNT_EN
        for (int c = 0; c < 65540; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
        chk("gc_saturate", gen_count, 16'hFFFF);
`else
        for (int c = 0; c < 40; c++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h99);
`endif
        chk("run_seed_frozen", seed,  held);
        chk("run_start_long",  start, 1'b1);
        check_model("long_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic er1();
        return 1'b1;
    endfunction

endmodule

// File: doc/seed_loader.md
SEED_LOADER -- requirements
Module: seed_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port row_data, input, 8 bits: one grid row offered by the writer.
REQ-004 SHALL have port row_valid, input, 1 bit: row_data is valid this cycle.
REQ-005 SHALL have port row_ready, output, 1 bit: the loader accepts a row this cycle.
REQ-006 SHALL have port load_cmd, input, 1 bit: begin a new seed load.
REQ-007 SHALL have port run_cmd, input, 1 bit: start evolution from the loaded seed.
REQ-008 SHALL have port halt_cmd, input, 1 bit: stop evolution.
REQ-009 SHALL have port seed, output, 64 bits: assembled 8x8 seed grid for the game controller.
REQ-010 SHALL have port start, output, 1 bit: run request driven to the game controller's start input.
REQ-011 SHALL have port loaded, output, 1 bit: a complete 8-row seed is held.
REQ-012 SHALL have port gen_count, output, 16 bits, present only under GEN_COUNT_EN: cycles spent running.

Function
REQ-013 SHALL implement states IDLE, LOAD, ARMED, RUN, with all outputs registered.
REQ-014 SHALL give commands the priority load_cmd > halt_cmd > run_cmd when several are asserted in one cycle.
REQ-015 IDLE: SHALL enter LOAD on load_cmd; SHALL ignore run_cmd and halt_cmd.
REQ-016 On any transition into LOAD, including load_cmd while already in LOAD, SHALL clear seed to 0, clear the row index to 0, and deassert loaded.
REQ-017 LOAD: SHALL assert row_ready; a row is accepted when row_valid and row_ready are both 1 on a rising clock edge.
REQ-018 An accepted row SHALL be written to seed[8*idx+7 : 8*idx], with row 0 in bits 7:0, and the index SHALL then increment.
REQ-019 On acceptance of the 8th row (idx 7), SHALL go to ARMED with row_ready=0 and loaded=1 in the next cycle; the index SHALL not wrap.
REQ-020 If load_cmd and an accepted row occur in the same cycle, the row SHALL be dropped and the load SHALL restart.
REQ-021 In every state other than LOAD, row_ready SHALL be 0 and row_valid SHALL be ignored.
REQ-022 ARMED: on run_cmd, SHALL go to RUN with start=1 from the next cycle.
REQ-023 RUN: start SHALL remain 1; halt_cmd SHALL return to ARMED with start=0 from the next cycle and seed retained.
REQ-024 load_cmd in ARMED or RUN SHALL enter LOAD and deassert start in the same edge.
REQ-025 seed SHALL change only in LOAD, so it is stable whenever start=1.

Reset
REQ-026 While reset=0, SHALL force state=IDLE, seed=0, start=0, row_ready=0, loaded=0, index=0 and gen_count=0 immediately, independent of clk.
REQ-027 Reset asserted mid-load or mid-run SHALL discard all partial state; the first edge after release SHALL evaluate from IDLE.

Configuration
REQ-028 With macro GEN_COUNT_EN defined, SHALL provide gen_count, which increments each cycle in RUN, saturates at 0xFFFF, holds in ARMED, and clears on entry to LOAD.
REQ-029 Without GEN_COUNT_EN, the gen_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Full load: load_cmd, then rows 0x01,0x02,...,0x08 streamed back-to-back -> seed=0x0807060504030201, loaded=1 and row_ready=0 one cycle after the 8th row.
REQ-031 Backpressure gaps: the same rows sent with row_valid toggling every other cycle -> identical seed; no row is duplicated or lost.
REQ-032 Run/halt: run_cmd in ARMED -> start=1 next cycle; halt_cmd after 10 cycles -> start=0 and, under GEN_COUNT_EN, gen_count=10 and held.
REQ-033 Priority: load_cmd+halt_cmd+run_cmd asserted together in RUN -> LOAD, start=0, seed=0, loaded=0.
REQ-034 Restart collision: load_cmd together with the 4th accepted row -> index back to 0, seed=0, and that row is absent from the final seed.
REQ-035 Async reset: reset=0 mid-LOAD between clock edges -> all outputs are 0 immediately; run_cmd after release has no effect.
